fifo_1d_22to64: RTL and testbench



---
 rtl/fifo_1d_22to64_pkg.sv | 57 +++++
 rtl/fifo_1d_out_reg.sv | 50 +++++
 rtl/fifo_1d_22to64.sv | 122 ++++++++++++
 tb/tb_fifo_1d_22to64.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_1d_22to64_pkg.sv
// Shared widths, slice offsets and chunk-placement helpers for the 22<->64 bit packers.
package fifo_1d_22to64_pkg;

    localparam int CHUNK_W = 22;
    localparam int WORD_W  = 64;
    localparam int TOP_W   = 20;

    localparam int OFF_HI  = 44;
    localparam int OFF_MID = 22;

    localparam int N_LONG  = 3;
    localparam int N_SHORT = 2;

    typedef enum logic [1:0] {
        ST_C0 = 2'd0,
        ST_C1 = 2'd1,
        ST_C2 = 2'd2
    } acc_state_e;

    // Slot that receives the chunk which closes a word of the given mode.
    function automatic acc_state_e last_slot(input logic short_mode);
        if (short_mode) begin
            return acc_state_e'(2'(N_SHORT - 1));
        end
        return acc_state_e'(2'(N_LONG - 1));
    endfunction

    // Contribution of one chunk to the 64-bit word, given its slot and the word mode.
    function automatic logic [WORD_W-1:0] place_chunk(
        input acc_state_e          slot,
        input logic                short_mode,
        input logic [CHUNK_W-1:0]  chunk
    );
        logic [WORD_W-1:0] w;
        w = '0;
        case (slot)
            ST_C0: begin
                if (short_mode) begin
                    w = WORD_W'(chunk) << OFF_MID;
                end else begin
                    w = WORD_W'(chunk[TOP_W-1:0]) << OFF_HI;
                end
            end
            ST_C1: begin
                if (short_mode) begin
                    w = WORD_W'(chunk);
                end else begin
                    w = WORD_W'(chunk) << OFF_MID;
                end
            end
            ST_C2: w = WORD_W'(chunk);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fifo_1d_out_reg.sv
// Single-entry valid/ready holding register for a packed word plus its short-mode flag.
module fifo_1d_out_reg
    import fifo_1d_22to64_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              short_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              short_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic              short_q, short_d;

    // The producer only loads when the slot is empty or draining this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        short_d = short_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            short_d = short_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            short_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            short_q <= short_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign short_o = short_q;

endmodule

// File: rtl/fifo_1d_22to64.sv
// Packs 22-bit chunks into 64-bit words (3 chunks long mode, 2 chunks short mode).
// Define FIFO_22TO64_CHECK_EN to build the sticky err flag for nonzero dropped bits.
//
// state | meaning
// ST_C0 | no chunk collected; next chunk starts a word and latches its mode
// ST_C1 | one chunk collected
// ST_C2 | two chunks collected (long mode only)
module fifo_1d_22to64
    import fifo_1d_22to64_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               a_short,
    input  logic [CHUNK_W-1:0] a_data,
    input  logic               a_valid,
    output logic               a_ready,
    output logic [WORD_W-1:0]  b_data,
    output logic               b_short,
    output logic               b_valid,
    input  logic               b_ready,
    output logic               err
);

    acc_state_e        state_q, state_d;
    logic              mode_q,  mode_d;
    logic [WORD_W-1:0] acc_q,   acc_d;

    logic              mode_eff;
    logic              completing_slot;
    logic              accept;
    logic              load;
    logic [WORD_W-1:0] contrib;
    logic [WORD_W-1:0] word;

    // On the first chunk the live a_short decides placement; afterwards the latched mode does.
    assign mode_eff        = (state_q == ST_C0) ? a_short : mode_q;
    assign completing_slot = (state_q != ST_C0) && (state_q == last_slot(mode_q));
    assign a_ready         = !completing_slot || !b_valid || b_ready;
    assign accept          = a_valid && a_ready;
    assign contrib         = place_chunk(state_q, mode_eff, a_data);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        load    = 1'b0;
        word    = acc_q | contrib;
        if (accept) begin
            case (state_q)
                ST_C0: begin
                    mode_d  = a_short;
                    acc_d   = contrib;
                    state_d = ST_C1;
                end
                ST_C1: begin
                    if (completing_slot) begin
                        load    = 1'b1;
                        state_d = ST_C0;
                    end else begin
                        acc_d   = acc_q | contrib;
                        state_d = ST_C2;
                    end
                end
                ST_C2: begin
                    load    = 1'b1;
                    state_d = ST_C0;
                end
                default: state_d = ST_C0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_C0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
        end
    end

    fifo_1d_out_reg u_out_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .data_i  (word),
        .short_i (mode_q),
        .ready_i (b_ready),
        .valid_o (b_valid),
        .data_o  (b_data),
        .short_o (b_short)
    );

`ifdef FIFO_22TO64_CHECK_EN
    logic err_q, err_d;

    // Long-mode chunk0 bits above TOP_W are dropped by the packer; flag them once seen.
    always_comb begin
        err_d = err_q;
        if (accept && (state_q == ST_C0) && !a_short &&
            (a_data[CHUNK_W-1:TOP_W] != '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_1d_22to64.sv
// Directed bench for fifo_1d_22to64 with a scoreboard of expected output words.
module tb_fifo_1d_22to64;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_short;
    logic [21:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [63:0] b_data;
    logic        b_short;
    logic        b_valid;
    logic        b_ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [64:0] exp_q[$];

`ifdef FIFO_22TO64_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    fifo_1d_22to64 dut (
        .clk     (clk),
        .rst     (rst),
        .a_short (a_short),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_short (b_short),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack(input logic [21:0] c0, input logic [21:0] c1,
                                         input logic [21:0] c2, input logic s);
        if (s) return {20'h0, c0, c1};
        return {c0[19:0], c1, c2};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [21:0] d, input logic s, output int waited);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_data  = d;
        a_short = s;
        @(negedge clk);
        while (!a_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_timeout", {63'b0, a_ready}, 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        waited  = n;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst && b_valid && b_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected observed %h expected none", b_data);
                end
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", b_data, e[63:0]);
                chk("sb_short", {63'b0, b_short}, {63'b0, e[64]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [21:0] c [9];
        logic [63:0] wa, wb, we;

        rst = 1'b1; a_valid = 1'b0; a_data = '0; a_short = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_b_valid", {63'b0, b_valid}, 64'd0);
        chk("rst_b_data",  b_data, 64'd0);
        chk("rst_b_short", {63'b0, b_short}, 64'd0);
        chk("rst_err",     {63'b0, err}, 64'd0);
        chk("rst_a_ready", {63'b0, a_ready}, 64'd1);

        // Long word
        b_ready = 1'b1;
        send(22'h01234, 1'b0, w);
        send(22'h159E26, 1'b0, w);
        chk("long_not_early", {63'b0, b_valid}, 64'd0);
        exp_q.push_back({1'b0, 64'h0123456789ABCDEF});
        send(22'h2BCDEF, 1'b0, w);
        chk("long_latency", {63'b0, b_valid}, 64'd1);
        chk("long_data", b_data, 64'h0123456789ABCDEF);
        idle(2);

        // Short word
        send(22'h3FFFFF, 1'b1, w);
        exp_q.push_back({1'b1, 64'h00000FFFFFC00001});
        send(22'h000001, 1'b0, w);
        chk("short_latency", {63'b0, b_valid}, 64'd1);
        chk("short_data", b_data, 64'h00000FFFFFC00001);
        chk("short_flag", {63'b0, b_short}, 64'd1);
        chk("short_no_err", {63'b0, err}, 64'd0);
        idle(2);

        // Back-to-back long words
        for (int i = 0; i < 9; i++) c[i] = 22'($urandom);
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 2)
                exp_q.push_back({1'b0, pack(c[i-2], c[i-1], c[i], 1'b0)});
            send(c[i], (i % 3 == 0) ? 1'b0 : 1'b1, w);
            chk("b2b_no_stall", 64'(w), 64'd0);
            chk("b2b_valid", {63'b0, b_valid}, (i % 3 == 2) ? 64'd1 : 64'd0);
        end
        idle(2);

        // Stall on output
        b_ready = 1'b0;
        for (int i = 0; i < 6; i++) c[i] = 22'($urandom);
        wa = pack(c[0], c[1], c[2], 1'b0);
        wb = pack(c[3], c[4], c[5], 1'b0);
        send(c[0], 1'b0, w);
        send(c[1], 1'b0, w);
        exp_q.push_back({1'b0, wa});
        send(c[2], 1'b0, w);
        chk("stall_valid", {63'b0, b_valid}, 64'd1);
        send(c[3], 1'b0, w);
        chk("stall_accept1", 64'(w), 64'd0);
        send(c[4], 1'b1, w);
        chk("stall_accept2", 64'(w), 64'd0);
        a_valid = 1'b1; a_data = c[5]; a_short = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_a_ready", {63'b0, a_ready}, 64'd0);
            chk("stall_hold_data", b_data, wa);
            chk("stall_hold_valid", {63'b0, b_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        b_ready = 1'b1;
        exp_q.push_back({1'b0, wb});
        @(negedge clk);
        chk("drain_a_ready", {63'b0, a_ready}, 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("drain_valid", {63'b0, b_valid}, 64'd1);
        chk("drain_data", b_data, wb);
        idle(3);

        // Reset with a held word and a partial word
        b_ready = 1'b0;
        send(22'h1A2B3C, 1'b0, w);
        send(22'h0F0F0F, 1'b0, w);
        send(22'h333333, 1'b0, w);
        chk("pre_rst_valid", {63'b0, b_valid}, 64'd1);
        send(22'h3ABCDE, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", {63'b0, b_valid}, 64'd0);
        chk("mid_rst_data", b_data, 64'd0);
        chk("mid_rst_a_ready", {63'b0, a_ready}, 64'd1);
        b_ready = 1'b1;
        we = pack(22'h012345, 22'h2AAAAA, 22'h0, 1'b1);
        send(22'h012345, 1'b1, w);
        chk("fresh_not_early", {63'b0, b_valid}, 64'd0);
        exp_q.push_back({1'b1, we});
        send(22'h2AAAAA, 1'b0, w);
        chk("fresh_data", b_data, we);
        chk("fresh_short", {63'b0, b_short}, 64'd1);
        idle(2);

        // Dropped-bit check
        chk("err_before", {63'b0, err}, 64'd0);
        send(22'h300000, 1'b0, w);
        chk("err_set", {63'b0, err}, {63'b0, EXP_ERR});
        send(22'h0ABCDE, 1'b0, w);
        exp_q.push_back({1'b0, pack(22'h300000, 22'h0ABCDE, 22'h155555, 1'b0)});
        send(22'h155555, 1'b0, w);
        chk("err_top_zero", {44'b0, b_data[63:44]}, 64'd0);
        idle(3);
        chk("err_sticky", {63'b0, err}, {63'b0, EXP_ERR});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("err_cleared", {63'b0, err}, 64'd0);

        idle(3);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
